// File: rtl/k_sync_fifo_t2.sv
// rtl/k_sync_fifo_t2.sv - single-clock FWFT FIFO with count, level flags, flush and sticky errors
//
// Purpose: general buffering element inside one clock domain. Read data falls
// through to rdata as soon as a word is stored; rget pops the head.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   wdata, wput    write data and request; accepted when wput && wrdy
//   wrdy           not full
//   rdata          head-of-queue data, valid while rrdy=1
//   rget           read request; pops when rget && rrdy
//   rrdy           not empty
//   flush          synchronous clear of contents, highest priority
//   count          occupancy 0..depth
//   afull, aempty  count >= afull_lvl, count <= aempty_lvl
//   ovf, udf       sticky: put while full / get while empty
//   err_clr        synchronous clear of ovf/udf
module k_sync_fifo_t2 #(
  parameter int data_size  = 8,
  parameter int depth      = 16,
  parameter int afull_lvl  = depth - 2,
  parameter int aempty_lvl = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [data_size-1:0]     wdata,
  input  logic                     wput,
  output logic                     wrdy,
  output logic [data_size-1:0]     rdata,
  input  logic                     rget,
  output logic                     rrdy,
  input  logic                     flush,
  output logic [$clog2(depth):0]   count,
  output logic                     afull,
  output logic                     aempty,
  output logic                     ovf,
  output logic                     udf,
  input  logic                     err_clr
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] afull_th  = (aw+1)'(afull_lvl);
  localparam logic [aw:0] aempty_th = (aw+1)'(aempty_lvl);

  logic [data_size-1:0] mem [depth];
  logic [aw:0]          wptr;
  logic [aw:0]          rptr;
  logic                 full;
  logic                 empty;
  logic                 we;
  logic                 re;

  // Status is a pure function of the registered pointers, so nothing here
  // depends combinationally on wput/rget.
  assign full   = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
  assign empty  = (wptr == rptr);
  assign wrdy   = ~full;
  assign rrdy   = ~empty;
  assign count  = wptr - rptr;
  assign afull  = (count >= afull_th);
  assign aempty = (count <= aempty_th);
  assign rdata  = mem[rptr[aw-1:0]];

  // Full with put+get accepts only the read and empty with put+get accepts
  // only the write: acceptance is judged on pre-edge readiness.
  assign we = wput & wrdy & ~flush;
  assign re = rget & rrdy & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; gated by rst_n so a reset edge cannot
  // complete a partial write.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[wptr[aw-1:0]] <= wdata;
  end

  // A same-cycle error event overrides err_clr; flush suppresses events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (err_clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (!flush && wput && !wrdy) ovf <= 1'b1;
      if (!flush && rget && !rrdy) udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_k_sync_fifo_t2.sv
// tb/tb_k_sync_fifo_t2.sv - directed self-checking bench for k_sync_fifo_t2
module tb_k_sync_fifo_t2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata = '0;
  logic       wput = 1'b0;
  logic       wrdy;
  logic [7:0] rdata;
  logic       rget = 1'b0;
  logic       rrdy;
  logic       flush = 1'b0;
  logic [4:0] count;
  logic       afull;
  logic       aempty;
  logic       ovf;
  logic       udf;
  logic       err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  k_sync_fifo_t2 dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wput(wput), .wrdy(wrdy),
    .rdata(rdata), .rget(rget), .rrdy(rrdy), .flush(flush), .count(count),
    .afull(afull), .aempty(aempty), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, let the rising edge act,
  // return at the next falling edge with inputs idle.
  task automatic cyc(input logic p, input logic [7:0] d, input logic g,
                     input logic f = 1'b0, input logic e = 1'b0);
    wput = p; wdata = d; rget = g; flush = f; err_clr = e;
    @(negedge clk);
    wput = 1'b0; rget = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_wrdy"}, 32'(wrdy), 32'd1);
    chk({tag, "_rrdy"}, 32'(rrdy), 32'd0);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_aempty"}, 32'(aempty), 32'd1);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_udf"}, 32'(udf), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_idle_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with 0x11..0x1F, head stays 0x11
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 8'(8'h11 + i), 1'b0);
      chk("fill_rrdy", 32'(rrdy), 32'd1);
      chk("fill_rdata", 32'(rdata), 32'h11);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_aempty", 32'(aempty), 32'((i + 1) <= 2));
      chk("fill_afull", 32'(afull), 32'((i + 1) >= 14));
    end

    // Reach full, then two dropped writes
    cyc(1'b1, 8'h20, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_wrdy", 32'(wrdy), 32'd0);
    chk("full_ovf0", 32'(ovf), 32'd0);
    cyc(1'b1, 8'hE1, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_ovf", 32'(ovf), 32'd1);
    // Full with put+get: only the read is accepted
    cyc(1'b1, 8'h99, 1'b1);
    chk("fullpg_count", 32'(count), 32'd15);
    chk("fullpg_rdata", 32'(rdata), 32'h12);
    for (int i = 0; i < 15; i++) begin
      chk("drain_rdata", 32'(rdata), 32'(8'h12 + i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rrdy", 32'(rrdy), 32'd0);
    chk("drain_udf", 32'(udf), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Streaming at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("strm_rdata", 32'(rdata), 32'(8'h40 + k));
      chk("strm_count", 32'(count), 32'd5);
      cyc(1'b1, 8'(8'h45 + k), 1'b1);
    end
    chk("strm_ovf", 32'(ovf), 32'd0);
    chk("strm_udf", 32'(udf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("strm_tail", 32'(rdata), 32'(8'h68 + i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("strm_empty", 32'(rrdy), 32'd0);

    // Empty with put+get: write accepted, udf sets
    cyc(1'b1, 8'hA5, 1'b1);
    chk("epg_udf", 32'(udf), 32'd1);
    chk("epg_count", 32'(count), 32'd1);
    chk("epg_rdata", 32'(rdata), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("epg_clr", 32'(udf), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("epg_pop", 32'(count), 32'd0);
    // err_clr loses to a same-cycle underflow
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("clr_vs_evt", 32'(udf), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_udf", 32'(udf), 32'd0);

    // Flush at count=9 with wput
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
    chk("pre_flush", 32'(count), 32'd9);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk_idle_reset("flush");
    cyc(1'b1, 8'h3C, 1'b0);
    chk("postfl_rdata", 32'(rdata), 32'h3C);
    chk("postfl_count", 32'(count), 32'd1);

    // Asynchronous reset mid-burst at count=7
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_rst", 32'(count), 32'd7);
    wput = 1'b1; wdata = 8'hBB;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rrdy", 32'(rrdy), 32'd0);
    chk("arst_wrdy", 32'(wrdy), 32'd1);
    wput = 1'b0;
    @(negedge clk);
    chk_idle_reset("arst");
    rst_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0);
    chk("rst_wr_rdata", 32'(rdata), 32'hC3);
    chk("rst_wr_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/k_sync_fifo_t2.md
Name: k_sync_fifo_t2

Overview:
- Single-clock, parametrised successor to the 2-deep dual-clock FIFO.
- Configurable data width and power-of-two depth.
- Uses the same put/get ready handshake as the 2-deep FIFO.
- Adds first-word-fall-through read data, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Used as the general buffering element inside one clock domain.

Parameters:
- data_size, 8, width of wdata/rdata in bits.
- depth, 16, number of entries; power of two, minimum 2.
- afull_lvl, depth-2, afull asserts when count >= afull_lvl; legal range 1..depth.
- aempty_lvl, 2, aempty asserts when count <= aempty_lvl; legal range 0..depth-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  data_size  write data.
- wput  in  1  write request; accepted when wput && wrdy.
- wrdy  out  1  FIFO not full.
- rdata  out  data_size  head-of-queue data; valid while rrdy=1.
- rget  in  1  read request; pops when rget && rrdy.
- rrdy  out  1  FIFO not empty.
- flush  in  1  synchronous clear of contents.
- count  out  $clog2(depth)+1  current occupancy, 0..depth.
- afull  out  1  almost-full flag.
- aempty  out  1  almost-empty flag.
- ovf  out  1  sticky: wput seen while wrdy=0.
- udf  out  1  sticky: rget seen while rrdy=0.
- err_clr  in  1  synchronous clear of ovf/udf.

Behaviour:
- Reset state (asynchronous, while rst_n=0):
  - wptr=rptr=0, count=0.
  - wrdy=1, rrdy=0, afull=0 (afull=1 only if afull_lvl=0), aempty=1, ovf=0, udf=0.
  - Storage array is not reset; rdata is don't-care while rrdy=0.
- Pointers:
  - $clog2(depth)+1 bits wide; MSB is the wrap bit, lower bits address storage.
  - Each pointer increments by 1 per accepted operation and wraps naturally modulo 2*depth.
  - Full when lower bits are equal and MSBs differ; empty when the pointers are equal.
- All outputs (wrdy, rrdy, count, afull, aempty, ovf, udf) are registered or derived purely from registered pointers; no combinational path from wput/rget to any output.
- Write:
  - On an accepted write, mem[wptr] <= wdata and wptr increments.
  - wput while wrdy=0 is dropped: no state change, ovf <= 1.
- Read (first-word-fall-through):
  - rdata = mem[rptr[addr]], combinational from registered state.
  - An accepted rget increments rptr; the next word appears the following cycle.
  - rget while rrdy=0: no state change, udf <= 1.
- Latency: a word written in cycle N is visible (rrdy=1, rdata valid) in cycle N+1.
- Simultaneous accepted put and get:
  - Both pointers advance; count unchanged.
  - Flags unchanged except as implied by the new count.
- Full with wput && rget:
  - Read accepted, write rejected (wrdy=0 at the sample edge); ovf sets.
  - No pass-through.
- Empty with wput && rget:
  - Write accepted, read rejected; udf sets.
  - No bypass; data appears next cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds depth or goes below 0.
- Flags: afull = (count >= afull_lvl), aempty = (count <= aempty_lvl), both evaluated on the registered count.
- flush:
  - Next edge: wptr=rptr=0, count=0, rrdy=0, wrdy=1.
  - Same-cycle wput and rget are ignored and do not set ovf/udf.
  - flush has priority over all other operations.
- err_clr: clears ovf/udf at the next edge; a same-cycle error event wins (flag stays 1).
- rst_n asserted mid-transfer: state returns to reset values immediately; no partial write completes.

Test Plan:
- Reset, then write 0x11..0x1F into an empty FIFO (data_size=8, depth=16) -> rrdy rises one cycle after the first write; rdata=0x11 with no rget; count tracks 1..15; aempty deasserts when count=3.
- Fill to 16 with wput held for 2 extra cycles -> wrdy=0 and afull=1 from count=14; extra words dropped; ovf=1; draining returns 16 words in order, the extra data never appears.
- Continuous put/get every cycle at count=5 across the pointer wrap (>=40 cycles) -> count stays 5; output sequence equals input sequence delayed by 5 words; no ovf/udf.
- Empty FIFO, assert rget + wput together with wdata=0xA5 -> udf=1, count=1, rdata=0xA5 next cycle; err_clr pulse -> udf=0.
- Count=9, assert flush with wput=1 -> next cycle count=0, rrdy=0, wrdy=1, ovf=0; a subsequent write of 0x3C reads back as 0x3C.
- Drop rst_n asynchronously mid-burst at count=7 -> count=0, rrdy=0, wrdy=1 before the next clock edge.
